calc_queue_engine: RTL
======================

// Module: calc_queue_engine
// PURPOSE
//  Queued multi-cycle unsigned calculator (add/sub/mul/div) with a command FIFO and
//  valid/ready handshakes on both sides. It replaces the fixed-stimulus calculator top
//  as the system-facing arithmetic unit. Tags travel with each command, so a master
//  can keep DEPTH+1 operations in flight.
// PARAMETERS
//  WIDTH  8  operand width in bits (>=2); results are 2*WIDTH bits
//  DEPTH  4  command FIFO entries (power of 2, >=2)
//  TAG_W  2  width of the tag carried from command to result
// PORTS
//  clock_i      in   1               single clock, all logic on rising edge
//  reset_i      in   1               synchronous, active-low reset
//  cmd_valid_i  in   1               command present on a_i/b_i/fct_i/tag_i
//  cmd_ready_o  out  1               FIFO can accept a command (= !full)
//  a_i          in   WIDTH           operand A, unsigned
//  b_i          in   WIDTH           operand B, unsigned
//  fct_i        in   2               00 add, 01 sub, 10 mul, 11 div
//  tag_i        in   TAG_W           user tag, returned unchanged on tag_o
//  res_valid_o  out  1               result registers valid
//  res_ready_i  in   1               consumer accepts result
//  res_o        out  2*WIDTH         main result
//  rem_o        out  2*WIDTH         remainder (div only, else 0)
//  tag_o        out  TAG_W           tag of the command that produced the result
//  err_o        out  1               divide-by-zero flag, qualified by res_valid_o
//  count_o      out  $clog2(DEPTH+1) FIFO occupancy
//  busy_o       out  1               engine not IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (reset_i==0 at posedge):
//   - FIFO emptied, FSM to IDLE.
//   - res_o/rem_o/tag_o/err_o/res_valid_o/count_o/busy_o = 0.
//   - cmd_ready_o forced 0 while reset_i is low.
//   - Reset mid-operation discards the queue and the in-flight op; no result is emitted.
//  Push: when cmd_valid_i && cmd_ready_o at posedge, {a,b,fct,tag} is written and count+1.
//   - cmd_ready_o depends only on count (no combinational path from pop).
//   - No bypass: a push into an empty FIFO can be popped at the next edge at the earliest.
//  FSM IDLE -> EXEC -> DONE:
//   - IDLE: if count!=0, pop the head at the edge, latch operands/fct/tag, go to EXEC.
//   - EXEC add: res = {0.., a+b} (carry in bit WIDTH); 1 cycle, then DONE.
//   - EXEC sub: res = 2*WIDTH-bit two's complement of a-b (borrow sign-extends); 1 cycle.
//   - EXEC mul: shift-add, one bit per cycle, WIDTH cycles; res = a*b.
//   - EXEC div: restoring, one bit per cycle, WIDTH cycles; res = a/b, rem = a%b,
//     both zero-extended.
//   - EXEC div with b==0: 1 cycle; res = all ones, rem = {0..,a}, err = 1.
//   - DONE: res_valid_o=1 and all result outputs held stable until res_ready_i.
//     On handshake: if count!=0, pop the next command in the same edge and go to EXEC,
//     else go to IDLE. res_valid_o drops after the edge unless a new DONE is reached.
//   - Latency from pop edge to res_valid_o high: 1 cycle (add/sub/div0), WIDTH (mul/div).
//  Ordering: results leave in command order, one at a time.
//   - Capacity is DEPTH queued + 1 in the engine.
//   - Push and pop in the same edge: count unchanged, both take effect.
//   - Pointers wrap modulo DEPTH.
//  Outputs: all registered except cmd_ready_o and busy_o (decoded from registered state).
// TESTING (WIDTH=8, DEPTH=4, TAG_W=2)
//  1. mul a=03 b=07 tag=1, res_ready=1 -> res=0x0015 rem=0 tag=1 err=0;
//     res_valid 8 cycles after pop.
//  2. add FF+01 -> 0x0100; sub 03-07 -> 0xFFFC; each valid 1 cycle after pop, rem=0.
//  3. div C8/07 -> res=0x001C rem=0x0004 after 8 cycles; div 2A/00 -> res=0xFFFF
//     rem=0x002A err=1 after 1 cycle.
//  4. res_ready=0, push 6 cmds tags 0..3,0,1 -> 5 accepted, cmd_ready=0 on the 6th,
//     count=4. Release -> tags return 0,1,2,3,0 in order, back-to-back pops.
//  5. Push on the same edge as a pop with count=4 -> push refused (ready=0);
//     with count=2 -> count stays 2.
//  6. reset_i low 1 cycle mid-mul -> all outputs 0, count=0, no result.
//     Next mul 0F*0F -> 0x00E1.

Source files
------------

// File: rtl/calc_queue_engine.sv
// Queued multi-cycle unsigned calculator: command FIFO feeding an add/sub/mul/div engine,
// with valid/ready handshakes on both the command and result sides.
module calc_queue_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [WIDTH-1:0]           a_i,
    input  logic [WIDTH-1:0]           b_i,
    input  logic [1:0]                 fct_i,
    input  logic [TAG_W-1:0]           tag_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [2*WIDTH-1:0]         res_o,
    output logic [2*WIDTH-1:0]         rem_o,
    output logic [TAG_W-1:0]           tag_o,
    output logic                       err_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       busy_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(WIDTH);
    localparam int RW = 2 * WIDTH;

    localparam logic [1:0] FCT_ADD = 2'b00;
    localparam logic [1:0] FCT_SUB = 2'b01;
    localparam logic [1:0] FCT_MUL = 2'b10;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] mem_a   [DEPTH];
    logic [WIDTH-1:0] mem_b   [DEPTH];
    logic [1:0]       mem_fct [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    logic [WIDTH-1:0] op_a, op_b;
    logic [1:0]       op_fct;
    logic [TAG_W-1:0] op_tag;
    logic [SW-1:0]    step;
    logic [RW-1:0]    acc, mcand;
    logic [WIDTH-1:0] mplier, quo, rmd;

    logic [RW-1:0]    acc_next;
    logic [WIDTH:0]   shifted, trial;
    logic             q_bit;
    logic [WIDTH-1:0] quo_next, rmd_next;
    logic             finish;

    // Ready comes from the registered count only, so a same-edge pop never frees a slot.
    assign cmd_ready_o = reset_i && (count != CW'(DEPTH));
    assign push        = cmd_valid_i && cmd_ready_o;
    assign count_o     = count;
    assign busy_o      = (state != IDLE) || (count != '0);

    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_a[wr_ptr]   <= a_i;
            mem_b[wr_ptr]   <= b_i;
            mem_fct[wr_ptr] <= fct_i;
            mem_tag[wr_ptr] <= tag_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) state <= IDLE;
        else          state <= next_state;
    end

    // A result handshake pops the next command on the same edge, keeping pops back-to-back.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (finish) next_state = DONE;
            end
            DONE: begin
                if (res_ready_i) begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        next_state = EXEC;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // One shift-add / restoring-division step; the remainder never exceeds b so WIDTH+1 bits suffice.
    always_comb begin
        acc_next = mplier[0] ? (acc + mcand) : acc;
        shifted  = {rmd, quo[WIDTH-1]};
        trial    = shifted - {1'b0, op_b};
        q_bit    = !trial[WIDTH];
        rmd_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], q_bit};
        finish   = (op_fct == FCT_ADD) || (op_fct == FCT_SUB) ||
                   ((op_fct != FCT_MUL) && (op_b == '0)) ||
                   (step == SW'(WIDTH - 1));
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            op_a        <= '0;
            op_b        <= '0;
            op_fct      <= '0;
            op_tag      <= '0;
            step        <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            quo         <= '0;
            rmd         <= '0;
            res_o       <= '0;
            rem_o       <= '0;
            tag_o       <= '0;
            err_o       <= 1'b0;
            res_valid_o <= 1'b0;
        end else begin
            res_valid_o <= (next_state == DONE);
            if (pop) begin
                op_a   <= mem_a[rd_ptr];
                op_b   <= mem_b[rd_ptr];
                op_fct <= mem_fct[rd_ptr];
                op_tag <= mem_tag[rd_ptr];
                step   <= '0;
                acc    <= '0;
                mcand  <= RW'(mem_a[rd_ptr]);
                mplier <= mem_b[rd_ptr];
                quo    <= mem_a[rd_ptr];
                rmd    <= '0;
            end else if (state == EXEC) begin
                step   <= step + SW'(1);
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                quo    <= quo_next;
                rmd    <= rmd_next;
                if (finish) begin
                    tag_o <= op_tag;
                    err_o <= 1'b0;
                    rem_o <= '0;
                    case (op_fct)
                        FCT_ADD: res_o <= RW'(op_a) + RW'(op_b);
                        FCT_SUB: res_o <= RW'(op_a) - RW'(op_b);
                        FCT_MUL: res_o <= acc_next;
                        default: begin
                            if (op_b == '0) begin
                                res_o <= '1;
                                rem_o <= RW'(op_a);
                                err_o <= 1'b1;
                            end else begin
                                res_o <= RW'(quo_next);
                                rem_o <= RW'(rmd_next);
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule
